// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester round-robin arbiter that shares one synchronous memory port
// between requesters A and B. Each requester issues single-word reads and
// writes via a req/gnt handshake; at most one access is accepted per cycle.
// The accepted command is registered onto the mem_* port, and read data is
// routed back to the requester that issued the read.
//
// Ports
//   clk                  single clock, rising edge
//   rst                  asynchronous, active-low reset
//   a_req / b_req        access request, held with its command until granted
//   a_we / b_we          1 = write, 0 = read
//   a_addr / b_addr      word address
//   a_wdata / b_wdata    write data
//   a_gnt / b_gnt        combinational grant; transfer on edge with req & gnt
//   a_rvalid / b_rvalid  one-cycle read-data strobe
//   a_rdata / b_rdata    registered read data, held between strobes
//   mem_en               registered memory access strobe
//   mem_we               registered write enable (qualified by mem_en)
//   mem_addr             registered address
//   mem_wdata            registered write data
//   mem_rdata            memory read data, valid the cycle after a read mem_en
//
// Read latency: handshake in cycle T -> mem_en in T+1 -> mem_rdata in T+2 ->
// x_rvalid / x_rdata in T+3.
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,

  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Priority state: which requester wins when both ask in the same cycle.
  localparam logic [0:0] PRI_A = 1'b0;
  localparam logic [0:0] PRI_B = 1'b1;

  localparam int NPORT = 2;  // index 0 = A, index 1 = B

  // --------------------------------------------------------------------------
  // Port-indexed views of the two requesters
  // --------------------------------------------------------------------------
  logic [NPORT-1:0]                 req;
  logic [NPORT-1:0]                 we;
  logic [NPORT-1:0][ADDR_WIDTH-1:0] addr_arr;
  logic [NPORT-1:0][DATA_WIDTH-1:0] wdata_arr;

  assign req       = {b_req, a_req};
  assign we        = {b_we, a_we};
  assign addr_arr  = {b_addr, a_addr};
  assign wdata_arr = {b_wdata, a_wdata};

  // --------------------------------------------------------------------------
  // Grant logic
  // --------------------------------------------------------------------------
  logic [0:0]       pri_reg;
  logic [0:0]       pri_next;
  logic [NPORT-1:0] gnt;
  logic             hs;   // a transfer happens at the next edge
  logic             sel;  // index of the granted requester

  // Gated by rst so no grant is visible while the block is held in reset.
  // A wins if it is alone or holds priority; otherwise B gets it if asking.
  always_comb begin
    gnt = '0;
    if (rst) begin
      if (req[0] && (!req[1] || (pri_reg == PRI_A))) begin
        gnt[0] = 1'b1;
      end else if (req[1]) begin
        gnt[1] = 1'b1;
      end
    end
  end

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];
  assign hs    = |gnt;
  assign sel   = gnt[1];

  // Round-robin: whoever was just served loses the next tie.
  always_comb begin
    pri_next = pri_reg;
    if (gnt[0]) begin
      pri_next = PRI_B;
    end else if (gnt[1]) begin
      pri_next = PRI_A;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pri_reg <= PRI_A;
    end else begin
      pri_reg <= pri_next;
    end
  end

  // --------------------------------------------------------------------------
  // Registered memory command
  // --------------------------------------------------------------------------
  logic                  mem_en_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;

  // Command fields only load on a handshake so they hold between accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      mem_en_reg <= hs;
      if (hs) begin
        mem_we_reg    <= we[sel];
        mem_addr_reg  <= addr_arr[sel];
        mem_wdata_reg <= wdata_arr[sel];
      end
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  // --------------------------------------------------------------------------
  // Read owner pipeline
  // --------------------------------------------------------------------------
  // Stage 0 lines up with mem_en (T+1), stage 1 with mem_rdata (T+2). Because
  // the memory returns data in issue order, a simple shift register is enough
  // to steer each return to its owner.
  logic [1:0] rd_vld_reg;
  logic [1:0] rd_own_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_reg <= '0;
      rd_own_reg <= '0;
    end else begin
      rd_vld_reg[0] <= hs && !we[sel];
      rd_own_reg[0] <= sel;
      rd_vld_reg[1] <= rd_vld_reg[0];
      rd_own_reg[1] <= rd_own_reg[0];
    end
  end

  // --------------------------------------------------------------------------
  // Per-requester return registers
  // --------------------------------------------------------------------------
  logic [NPORT-1:0]                 rvalid_vec;
  logic [NPORT-1:0][DATA_WIDTH-1:0] rdata_vec;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_ret
    logic                  hit;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    assign hit = rd_vld_reg[1] && (rd_own_reg[1] == 1'(gi));

    // rdata only loads on this requester's own return, so it holds its
    // value across the other requester's strobes.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= hit;
        if (hit) begin
          rdata_reg <= mem_rdata;
        end
      end
    end

    assign rvalid_vec[gi] = rvalid_reg;
    assign rdata_vec[gi]  = rdata_reg;
  end

  assign a_rvalid = rvalid_vec[0];
  assign b_rvalid = rvalid_vec[1];
  assign a_rdata  = rdata_vec[0];
  assign b_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A small synchronous memory model sits on the
// mem_* port. Inputs are driven 1 ns after the rising edge; combinational
// grants are checked 1 ns later, registered outputs right after the edge.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int DW = 3;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          a_req, b_req;
  logic          a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt;
  logic          a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem_model [4];

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: write on mem_en&we, registered read otherwise.
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_model[mem_addr] <= mem_wdata;
      end else begin
        mem_rdata <= mem_model[mem_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset with both requests high ----------------
    rst = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    a_we = 1'b0;  b_we = 1'b0;
    a_addr = '0;  b_addr = '0;
    a_wdata = '0; b_wdata = '0;
    step();
    step();
    #1;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    $display("reset: gnt=%b%b mem_en=%b", a_gnt, b_gnt, mem_en);

    // ---------------- release: A first; preload addr0=2, addr1=7 ----------------
    step();
    rst = 1'b1;
    a_we = 1'b1; a_addr = 2'd0; a_wdata = 3'b010;
    b_we = 1'b1; b_addr = 2'd1; b_wdata = 3'b111;
    #1;
    chk("rel_a_gnt", a_gnt, 1);
    chk("rel_b_gnt", b_gnt, 0);
    step();
    chk("pre0_mem_en", mem_en, 1);
    chk("pre0_mem_we", mem_we, 1);
    chk("pre0_mem_addr", mem_addr, 0);
    chk("pre0_mem_wdata", mem_wdata, 3'b010);
    a_req = 1'b0;
    #1;
    chk("pre1_a_gnt", a_gnt, 0);
    chk("pre1_b_gnt", b_gnt, 1);
    step();
    chk("pre1_mem_addr", mem_addr, 1);
    chk("pre1_mem_wdata", mem_wdata, 3'b111);
    $display("preload: addr0=010 addr1=111 written");
    b_req = 1'b0;

    // ---------------- single write then read by A ----------------
    a_req = 1'b1; a_we = 1'b1; a_addr = 2'd2; a_wdata = 3'b101;
    #1;
    chk("sw_wr_gnt", a_gnt, 1);
    step();  // T+1
    chk("sw_mem_en", mem_en, 1);
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_addr", mem_addr, 2);
    chk("sw_mem_wdata", mem_wdata, 3'b101);
    a_we = 1'b0;
    #1;
    chk("sw_rd_gnt", a_gnt, 1);
    step();  // T+2
    chk("sr_mem_en", mem_en, 1);
    chk("sr_mem_we", mem_we, 0);
    chk("sr_mem_addr", mem_addr, 2);
    a_req = 1'b0;
    step();  // T+3
    chk("sr_idle_mem_en", mem_en, 0);
    chk("sr_early_a_rvalid", a_rvalid, 0);
    chk("sr_hold_mem_addr", mem_addr, 2);
    step();  // T+4
    chk("sr_a_rvalid", a_rvalid, 1);
    chk("sr_a_rdata", a_rdata, 3'b101);
    chk("sr_b_rvalid", b_rvalid, 0);
    $display("single w/r: a_rvalid=%b a_rdata=%b", a_rvalid, a_rdata);
    step();  // T+5
    chk("sr_a_rvalid_off", a_rvalid, 0);
    chk("sr_a_rdata_hold", a_rdata, 3'b101);

    // B writes addr3 alone so the priority returns to A
    b_req = 1'b1; b_we = 1'b1; b_addr = 2'd3; b_wdata = 3'b000;
    #1;
    chk("bw_b_gnt", b_gnt, 1);
    step();

    // ---------------- contention: both read for 4 cycles ----------------
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd0;
    b_we = 1'b0; b_addr = 2'd1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
      #1;
      chk("ct_a_gnt", a_gnt, 32'((k < 4) && (k % 2 == 0)));
      chk("ct_b_gnt", b_gnt, 32'((k < 4) && (k % 2 == 1)));
      chk("ct_a_rvalid", a_rvalid, 32'((k == 3) || (k == 5)));
      chk("ct_b_rvalid", b_rvalid, 32'((k == 4) || (k == 6)));
      if ((k == 3) || (k == 5)) chk("ct_a_rdata", a_rdata, 3'b010);
      if ((k == 4) || (k == 6)) chk("ct_b_rdata", b_rdata, 3'b111);
      $display("contention k=%0d gnt=%b%b rv=%b%b", k, a_gnt, b_gnt, a_rvalid, b_rvalid);
      step();
    end

    // ---------------- mixed: A writes addr3, B reads addr3 ----------------
    a_req = 1'b1; a_we = 1'b1; a_addr = 2'd3; a_wdata = 3'b100;
    b_req = 1'b1; b_we = 1'b0; b_addr = 2'd3;
    #1;
    chk("mx_a_gnt", a_gnt, 1);
    chk("mx_b_gnt", b_gnt, 0);
    step();  // M1
    a_req = 1'b0;
    #1;
    chk("mx_b_gnt2", b_gnt, 1);
    chk("mx_a_gnt2", a_gnt, 0);
    step();  // M2
    b_req = 1'b0;
    step();  // M3
    chk("mx_early_b_rvalid", b_rvalid, 0);
    chk("mx_b_rdata_hold", b_rdata, 3'b111);
    step();  // M4
    chk("mx_b_rvalid", b_rvalid, 1);
    chk("mx_b_rdata", b_rdata, 3'b100);
    chk("mx_a_rvalid", a_rvalid, 0);
    $display("mixed: b_rvalid=%b b_rdata=%b", b_rvalid, b_rdata);

    // ---------------- rewrite memory to 1,2,3,4 ----------------
    a_req = 1'b1; a_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_addr = AW'(k);
      a_wdata = DW'(k + 1);
      #1;
      chk("wr_a_gnt", a_gnt, 1);
      step();
    end
    a_req = 1'b0;

    // ---------------- back-to-back reads by B ----------------
    b_req = 1'b1; b_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) b_addr = AW'(k);
      if (k == 4) b_req = 1'b0;
      #1;
      chk("bb_b_gnt", b_gnt, 32'(k < 4));
      chk("bb_b_rvalid", b_rvalid, 32'((k >= 3) && (k <= 6)));
      chk("bb_a_rvalid", a_rvalid, 0);
      if ((k >= 3) && (k <= 6)) chk("bb_b_rdata", b_rdata, 32'(k - 2));
      $display("b2b k=%0d b_gnt=%b b_rvalid=%b b_rdata=%0d", k, b_gnt, b_rvalid, b_rdata);
      step();
    end

    // ---------------- reset mid-flight ----------------
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd0;
    #1;
    chk("mf_gnt0", a_gnt, 1);
    step();  // P1
    a_addr = 2'd1;
    #1;
    chk("mf_gnt1", a_gnt, 1);
    step();  // P2
    a_req = 1'b0;
    chk("mf_mem_en_before", mem_en, 1);
    #4;
    rst = 1'b0;
    #1;
    chk("mf_mem_en", mem_en, 0);
    chk("mf_a_rvalid", a_rvalid, 0);
    chk("mf_a_rdata", a_rdata, 0);
    chk("mf_b_rdata", b_rdata, 0);
    chk("mf_a_gnt", a_gnt, 0);
    $display("mid-flight reset: mem_en=%b a_rvalid=%b", mem_en, a_rvalid);
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("mf_quiet_a_rvalid", a_rvalid, 0);
      chk("mf_quiet_b_rvalid", b_rvalid, 0);
      chk("mf_quiet_mem_en", mem_en, 0);
      step();
    end

    // new read after release comes back normally
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd2;
    #1;
    chk("nr_a_gnt", a_gnt, 1);
    step();
    a_req = 1'b0;
    step();
    chk("nr_early_a_rvalid", a_rvalid, 0);
    step();
    chk("nr_a_rvalid", a_rvalid, 1);
    chk("nr_a_rdata", a_rdata, 3);
    $display("reissued read: a_rvalid=%b a_rdata=%0d", a_rvalid, a_rdata);
    step();
    chk("nr_a_rvalid_off", a_rvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
